// File: rtl/cam_window_capture.sv
// cam_window_capture
// Capture stage between the camera pixel assembler and the frame buffer.
// It tracks the (x,y) position of every pixel in a camera frame and writes
// only a rectangular window of pixels to buffer port A. Each pixel is written
// either as raw RGB565 or as 8-bit luma. The stage also provides frame-aligned
// freeze, a completed-frame counter and sticky detection of short frames.
//
// Ports
//   clk         pixel-domain clock, all logic on its rising edge
//   rst         asynchronous active-high reset
//   pix_valid   one-cycle strobe, pix_data holds a complete pixel
//   pix_data    RGB565 pixel, R=[15:11] G=[10:5] B=[4:0]
//   frame_start one-cycle pulse at the start of each camera frame
//   mode        0 = RGB565 passthrough, 1 = gray8 in wr_data[7:0]
//   freeze      level, hold the last completed frame in the buffer
//   wr_en       buffer write strobe
//   wr_addr     buffer write address, row-major inside the window
//   wr_data     buffer write data
//   frame_done  one-cycle pulse in the write slot of a frame's last pixel
//   capturing   high while capturing (one cycle behind the state register)
//   frame_cnt   completed-frame counter, wraps 255 -> 0
//   sync_err    sticky flag for a frame_start that arrives inside a frame
module cam_window_capture #(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480,
  parameter int WIN_X0  = 0,
  parameter int WIN_Y0  = 0,
  parameter int WIN_W   = 150,
  parameter int WIN_H   = 150,
  parameter int ADDR_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [15:0]       pix_data,
  input  logic              frame_start,
  input  logic              mode,
  input  logic              freeze,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              capturing,
  output logic [7:0]        frame_cnt,
  output logic              sync_err
);

  // Counters are one bit wider than strictly needed. This lets a window edge
  // equal to the frame size still fit in the counter width.
  localparam int XW = $clog2(FRAME_W + 1);
  localparam int YW = $clog2(FRAME_H + 1);

  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
  localparam logic [XW-1:0] X_LO   = XW'(WIN_X0);
  localparam logic [YW-1:0] Y_LO   = YW'(WIN_Y0);
  localparam logic [XW-1:0] X_SPAN = XW'(WIN_W);
  localparam logic [YW-1:0] Y_SPAN = YW'(WIN_H);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr_cnt;

  logic              restart;
  logic              accept;
  logic              in_win;
  logic              last_pix;
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;
  logic [ADDR_W-1:0] cur_addr;
  logic [XW-1:0]     x_off;
  logic [YW-1:0]     y_off;

  logic              s1_valid;
  logic              s1_last;
  logic              s1_mode;
  logic [15:0]       s1_pix;
  logic [ADDR_W-1:0] s1_addr;

  logic [7:0]        r8;
  logic [7:0]        g8;
  logic [7:0]        b8;
  logic [15:0]       luma_sum;
  logic [7:0]        gray;

  // A frame restart takes effect before a pixel in the same cycle, so that
  // pixel is treated as (0,0) with address 0 of the new frame. The window test
  // subtracts the window origin and does one unsigned compare. Positions left
  // of (or above) the origin wrap to large values and fall outside the span.
  always_comb begin
    restart  = frame_start && ((state == CAPTURE) || ((state == IDLE) && !freeze));
    accept   = pix_valid && ((state == CAPTURE) || restart);
    cur_x    = restart ? '0 : x;
    cur_y    = restart ? '0 : y;
    cur_addr = restart ? '0 : addr_cnt;
    x_off    = cur_x - X_LO;
    y_off    = cur_y - Y_LO;
    in_win   = (x_off < X_SPAN) && (y_off < Y_SPAN);
    last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);
  end

  // Control FSM, position counters and pipeline stage 1.
  // A pixel that arrives while freeze is held still completes the current frame.
  // The freeze level is checked only on the frame's last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      y         <= '0;
      addr_cnt  <= '0;
      capturing <= 1'b0;
      sync_err  <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_mode   <= 1'b0;
      s1_pix    <= '0;
      s1_addr   <= '0;
    end else begin
      capturing <= (state == CAPTURE);
      s1_valid  <= accept && in_win;
      s1_last   <= accept && last_pix;
      s1_mode   <= mode;
      s1_pix    <= pix_data;
      s1_addr   <= cur_addr;

      if (restart) begin
        if (state == CAPTURE) sync_err <= 1'b1;
        state    <= CAPTURE;
        x        <= '0;
        y        <= '0;
        addr_cnt <= '0;
      end

      if (accept) begin
        if (in_win) addr_cnt <= cur_addr + 1'b1;
        if (cur_x == X_LAST) begin
          x <= '0;
          if (cur_y == Y_LAST) begin
            y     <= '0;
            state <= freeze ? HOLD : IDLE;
          end else begin
            y <= cur_y + 1'b1;
          end
        end else begin
          x <= cur_x + 1'b1;
        end
      end

      if ((state == HOLD) && !freeze) state <= IDLE;
    end
  end

  // Luma from RGB565. Each channel is first expanded to 8 bits by repeating
  // its top bits. The weighted sum of 255s peaks at 65280, so 16 bits is enough.
  always_comb begin
    r8       = {s1_pix[15:11], s1_pix[15:13]};
    g8       = {s1_pix[10:5],  s1_pix[10:9]};
    b8       = {s1_pix[4:0],   s1_pix[4:2]};
    luma_sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    gray     = 8'(luma_sum >> 8);
  end

  // Pipeline stage 2: buffer write port, frame_done and the frame counter.
  // Both modes have the same latency, so the mode can change per pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wr_en      <= s1_valid;
      wr_addr    <= s1_addr;
      wr_data    <= s1_mode ? {8'd0, gray} : s1_pix;
      frame_done <= s1_last;
      if (s1_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_window_capture.sv
// tb_cam_window_capture
// Directed bench for cam_window_capture. It uses a 16x8 frame with a 4x2
// window at (10,5). Writes and frame_done pulses are logged on the falling
// edge. Each scenario is then compared with hand-computed contents.
module tb_cam_window_capture;

  localparam int FW = 16;
  localparam int FH = 8;
  localparam int X0 = 10;
  localparam int Y0 = 5;
  localparam int WW = 4;
  localparam int WH = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_valid = 1'b0;
  logic [15:0]   pix_data = '0;
  logic          frame_start = 1'b0;
  logic          mode = 1'b0;
  logic          freeze = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          frame_done;
  logic          capturing;
  logic [7:0]    frame_cnt;
  logic          sync_err;

  cam_window_capture #(
    .FRAME_W(FW), .FRAME_H(FH), .WIN_X0(X0), .WIN_Y0(Y0),
    .WIN_W(WW), .WIN_H(WH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
    .frame_start(frame_start), .mode(mode), .freeze(freeze),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .capturing(capturing),
    .frame_cnt(frame_cnt), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int wAddr[$];
  int wData[$];
  int wCyc[$];
  int doneCnt = 0;
  int doneCyc = 0;
  int originCyc = 0;
  int lastPixCyc = 0;

  // Window pixels for the gray scenario and their hand-computed luma values.
  logic [15:0] grayIn  [0:7] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0,
                                 16'h001F, 16'h8410, 16'h001F, 16'h8410};
  logic [7:0]  grayOut [0:7] = '{8'hFF, 8'h00, 8'h4C, 8'h95,
                                 8'h1C, 8'h82, 8'h1C, 8'h82};

  // Record every buffer write and frame_done pulse away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wAddr.push_back(int'(wr_addr));
      wData.push_back(int'(wr_data));
      wCyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      doneCnt++;
      doneCyc = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    wAddr.delete();
    wData.delete();
    wCyc.delete();
    doneCnt = 0;
  endtask

  function automatic logic [15:0] pixVal(input int x, input int y, input bit grayMode);
    if (!grayMode) return 16'(y * FW + x);
    if (x >= X0 && x < X0 + WW && y >= Y0 && y < Y0 + WH)
      return grayIn[(y - Y0) * WW + (x - X0)];
    return 16'(x * 7 + y * 3);
  endfunction

  // Sends one frame of back-to-back pixels. If combine is set, frame_start
  // shares its cycle with pixel (0,0). freezeLine >= 0 raises freeze at the
  // start of that line.
  task automatic applyStimulus(input int lines, input bit grayMode, input bit combine, input int freezeLine);
    mode = grayMode;
    if (!combine) begin
      @(posedge clk); #1;
      frame_start = 1'b1;
      pix_valid = 1'b0;
    end
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < FW; x++) begin
        @(posedge clk); #1;
        frame_start = combine && (x == 0) && (y == 0);
        if (x == 0 && y == freezeLine) freeze = 1'b1;
        pix_valid = 1'b1;
        pix_data = pixVal(x, y, grayMode);
        if (x == X0 && y == Y0) originCyc = cyc;
        lastPixCyc = cyc;
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic verifyFrame(input string tag, input bit grayMode);
    logic [15:0] exp;
    checkOutput({tag, "_count"}, wAddr.size(), WW * WH);
    for (int i = 0; i < wAddr.size() && i < WW * WH; i++) begin
      if (grayMode) exp = {8'd0, grayOut[i]};
      else exp = 16'((Y0 + i / WW) * FW + X0 + i % WW);
      checkOutput($sformatf("%s_addr%0d", tag, i), wAddr[i], i);
      checkOutput($sformatf("%s_data%0d", tag, i), wData[i], {16'd0, exp});
    end
    checkOutput({tag, "_done_cnt"}, doneCnt, 1);
    checkOutput({tag, "_done_lat"}, doneCyc - lastPixCyc, 2);
    if (wCyc.size() > 0) checkOutput({tag, "_first_lat"}, wCyc[0] - originCyc, 2);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_en"}, wr_en, 0);
    checkOutput({tag, "_wr_addr"}, wr_addr, 0);
    checkOutput({tag, "_wr_data"}, wr_data, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
    checkOutput({tag, "_capturing"}, capturing, 0);
    checkOutput({tag, "_frame_cnt"}, frame_cnt, 0);
    checkOutput({tag, "_sync_err"}, sync_err, 0);
  endtask

  initial begin
    idle(3);
    checkAllZero("reset");
    rst = 1'b0;
    idle(2);

    // Raster frame in RGB565 mode.
    clearLog();
    applyStimulus(FH, 1'b0, 1'b0, -1);
    idle(4);
    verifyFrame("raster", 1'b0);
    checkOutput("raster_cnt", frame_cnt, 1);
    checkOutput("raster_capturing", capturing, 0);

    // Gray conversion, including white, black, pure red, green and blue.
    clearLog();
    applyStimulus(FH, 1'b1, 1'b0, -1);
    idle(4);
    verifyFrame("gray", 1'b1);
    checkOutput("gray_cnt", frame_cnt, 2);

    // Freeze raised mid-frame: this frame is still written in full.
    clearLog();
    applyStimulus(FH, 1'b0, 1'b0, 3);
    idle(4);
    verifyFrame("frz1", 1'b0);
    checkOutput("frz1_cnt", frame_cnt, 3);

    // Two frames while frozen are ignored.
    clearLog();
    applyStimulus(FH, 1'b0, 1'b0, -1);
    applyStimulus(FH, 1'b0, 1'b0, -1);
    idle(4);
    checkOutput("frz_nowrite", wAddr.size(), 0);
    checkOutput("frz_nodone", doneCnt, 0);
    checkOutput("frz_cnt", frame_cnt, 3);
    checkOutput("frz_capturing", capturing, 0);

    // Released: capture resumes at the next frame_start.
    freeze = 1'b0;
    idle(3);
    clearLog();
    applyStimulus(FH, 1'b0, 1'b0, -1);
    idle(4);
    verifyFrame("frz4", 1'b0);
    checkOutput("frz4_cnt", frame_cnt, 4);

    // Short frame, then a restart whose frame_start shares a cycle with pixel (0,0).
    checkOutput("sync_pre", sync_err, 0);
    clearLog();
    applyStimulus(6, 1'b0, 1'b0, -1);
    applyStimulus(FH, 1'b0, 1'b1, -1);
    idle(4);
    checkOutput("sync_total", wAddr.size(), 12);
    for (int i = 0; i < 4 && wAddr.size() > 0; i++) begin
      checkOutput($sformatf("sync_short_addr%0d", i), wAddr[0], i);
      void'(wAddr.pop_front());
      void'(wData.pop_front());
      void'(wCyc.pop_front());
    end
    originCyc = originCyc;
    verifyFrame("sync", 1'b0);
    checkOutput("sync_err", sync_err, 1);
    checkOutput("sync_cnt", frame_cnt, 5);
    idle(5);
    checkOutput("sync_sticky", sync_err, 1);

    // Reset in the middle of the window with writes in flight.
    @(posedge clk); #1;
    frame_start = 1'b1;
    mode = 1'b0;
    for (int k = 0; k <= Y0 * FW + X0 + 1; k++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      pix_valid = 1'b1;
      pix_data = pixVal(k % FW, k / FW, 1'b0);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkAllZero("midrst");
    idle(2);
    rst = 1'b0;
    clearLog();
    for (int k = 0; k < FW; k++) begin
      @(posedge clk); #1;
      pix_valid = 1'b1;
      pix_data = 16'(k);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    idle(4);
    checkOutput("postrst_nowrite", wAddr.size(), 0);
    checkOutput("postrst_capturing", capturing, 0);
    clearLog();
    applyStimulus(FH, 1'b0, 1'b0, -1);
    idle(4);
    verifyFrame("postrst", 1'b0);
    checkOutput("postrst_cnt", frame_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
